// File: rtl/mem_rd_arbiter.sv
// Arbitrates the instruction and data read requesters onto one MMU read port,
// tracks outstanding reads in order and routes each response to its owner.
module mem_rd_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic        INST_WAIT,
    output logic        INST_RVALID,
    output logic [31:0] INST_ROADDR,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic        DATA_WAIT,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_ROADDR,
    output logic [31:0] DATA_RDATA,
    input  logic        FLUSH,
    output logic        MEM_RDEN,
    output logic [31:0] MEM_RIADDR,
    input  logic        MEM_WAIT,
    input  logic        MEM_RVALID,
    input  logic [31:0] MEM_ROADDR,
    input  logic [31:0] MEM_RDATA,
    output logic        ERR
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT   = (AW + 1)'(DEPTH);
    localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic        ID_INST    = 1'b0;
    localparam logic        ID_DATA    = 1'b1;

    logic [DEPTH-1:0] id_q, id_d, disc_q, disc_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [3:0]       starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;
    logic             inst_rvalid_q, inst_rvalid_d, data_rvalid_q, data_rvalid_d;
    logic [31:0]      inst_roaddr_q, inst_roaddr_d, inst_rdata_q, inst_rdata_d;
    logic [31:0]      data_roaddr_q, data_roaddr_d, data_rdata_q, data_rdata_d;

    logic grant_inst, grant_data, full, empty, issue, pop, head_id, head_disc;

    // An instruction request never wins during FLUSH, so FLUSH cannot push an inst entry.
    always_comb begin
        grant_inst = INST_RDEN && !FLUSH && (!DATA_RDEN || starve_cnt_q == STARVE_MAX);
        grant_data = DATA_RDEN && !grant_inst;
        full       = (count_q == FULL_CNT);
        empty      = (count_q == '0);
        MEM_RDEN   = (grant_inst || grant_data) && !full;
        MEM_RIADDR = grant_inst ? INST_RIADDR : (grant_data ? DATA_RIADDR : 32'h0);
        issue      = MEM_RDEN && !MEM_WAIT;
        INST_WAIT  = INST_RDEN && !(issue && grant_inst);
        DATA_WAIT  = DATA_RDEN && !(issue && grant_data);
        pop        = MEM_RVALID && !empty;
        head_id    = id_q[rd_ptr_q];
        head_disc  = disc_q[rd_ptr_q] || (FLUSH && head_id == ID_INST);
    end

    always_comb begin
        id_d          = id_q;
        disc_d        = disc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        starve_cnt_d  = starve_cnt_q;
        err_d         = err_q || (MEM_RVALID && empty);
        inst_rvalid_d = 1'b0;
        inst_roaddr_d = inst_roaddr_q;
        inst_rdata_d  = inst_rdata_q;
        data_rvalid_d = 1'b0;
        data_roaddr_d = data_roaddr_q;
        data_rdata_d  = data_rdata_q;

        // Marking stale slots is harmless: a push always rewrites its discard bit.
        if (FLUSH) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (id_q[i] == ID_INST) disc_d[i] = 1'b1;
            end
        end

        if (issue) begin
            id_d[wr_ptr_q]   = grant_data ? ID_DATA : ID_INST;
            disc_d[wr_ptr_q] = 1'b0;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (!head_disc) begin
                if (head_id == ID_INST) begin
                    inst_rvalid_d = 1'b1;
                    inst_roaddr_d = MEM_ROADDR;
                    inst_rdata_d  = MEM_RDATA;
                end else begin
                    data_rvalid_d = 1'b1;
                    data_roaddr_d = MEM_ROADDR;
                    data_rdata_d  = MEM_RDATA;
                end
            end
        end

        case ({issue, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (!INST_RDEN || (issue && grant_inst)) begin
            starve_cnt_d = 4'd0;
        end else if (issue && grant_data && starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            id_q          <= '0;
            disc_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            starve_cnt_q  <= '0;
            err_q         <= 1'b0;
            inst_rvalid_q <= 1'b0;
            inst_roaddr_q <= '0;
            inst_rdata_q  <= '0;
            data_rvalid_q <= 1'b0;
            data_roaddr_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            id_q          <= id_d;
            disc_q        <= disc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            starve_cnt_q  <= starve_cnt_d;
            err_q         <= err_d;
            inst_rvalid_q <= inst_rvalid_d;
            inst_roaddr_q <= inst_roaddr_d;
            inst_rdata_q  <= inst_rdata_d;
            data_rvalid_q <= data_rvalid_d;
            data_roaddr_q <= data_roaddr_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

    assign INST_RVALID = inst_rvalid_q;
    assign INST_ROADDR = inst_roaddr_q;
    assign INST_RDATA  = inst_rdata_q;
    assign DATA_RVALID = data_rvalid_q;
    assign DATA_ROADDR = data_roaddr_q;
    assign DATA_RDATA  = data_rdata_q;
    assign ERR         = err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: single read, contention, queue full,
// MEM_WAIT stall, FLUSH discard and spurious-response error flag.
module tb_mem_rd_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        INST_RDEN, DATA_RDEN, FLUSH, MEM_WAIT, MEM_RVALID;
    logic [31:0] INST_RIADDR, DATA_RIADDR, MEM_ROADDR, MEM_RDATA;
    logic        INST_WAIT, INST_RVALID, DATA_WAIT, DATA_RVALID, MEM_RDEN, ERR;
    logic [31:0] INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA, MEM_RIADDR;

    int vectors = 0;
    int miscompares = 0;

    mem_rd_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_WAIT(INST_WAIT),
        .INST_RVALID(INST_RVALID), .INST_ROADDR(INST_ROADDR), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_WAIT(DATA_WAIT),
        .DATA_RVALID(DATA_RVALID), .DATA_ROADDR(DATA_ROADDR), .DATA_RDATA(DATA_RDATA),
        .FLUSH(FLUSH), .MEM_RDEN(MEM_RDEN), .MEM_RIADDR(MEM_RIADDR), .MEM_WAIT(MEM_WAIT),
        .MEM_RVALID(MEM_RVALID), .MEM_ROADDR(MEM_ROADDR), .MEM_RDATA(MEM_RDATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic ie, input logic [31:0] ia, input logic de,
                                 input logic [31:0] da, input logic fl, input logic mw,
                                 input logic mv, input logic [31:0] ma, input logic [31:0] md);
        INST_RDEN = ie; INST_RIADDR = ia; DATA_RDEN = de; DATA_RIADDR = da;
        FLUSH = fl; MEM_WAIT = mw; MEM_RVALID = mv; MEM_ROADDR = ma; MEM_RDATA = md;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBitOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic endCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RST = 1'b1;
        idle();
        repeat (2) endCycle();
        RST = 1'b0;

        // Reset values
        idle();
        checkBitOutput("rst_inst_rvalid", INST_RVALID, 1'b0);
        checkOutput("rst_inst_roaddr", INST_ROADDR, 32'h0);
        checkOutput("rst_inst_rdata", INST_RDATA, 32'h0);
        checkBitOutput("rst_data_rvalid", DATA_RVALID, 1'b0);
        checkOutput("rst_data_roaddr", DATA_ROADDR, 32'h0);
        checkBitOutput("rst_err", ERR, 1'b0);
        checkBitOutput("rst_mem_rden", MEM_RDEN, 1'b0);
        checkOutput("rst_mem_riaddr", MEM_RIADDR, 32'h0);
        checkBitOutput("rst_inst_wait", INST_WAIT, 1'b0);
        checkBitOutput("rst_data_wait", DATA_WAIT, 1'b0);

        // Single instruction read, answered three cycles later
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkBitOutput("single_mem_rden", MEM_RDEN, 1'b1);
        checkOutput("single_mem_riaddr", MEM_RIADDR, 32'h100);
        checkBitOutput("single_inst_wait", INST_WAIT, 1'b0);
        endCycle();
        idle();
        checkBitOutput("single_no_reissue", MEM_RDEN, 1'b0);
        endCycle();
        idle();
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h100, 32'hDEADBEEF);
        checkBitOutput("single_rvalid_early", INST_RVALID, 1'b0);
        endCycle();
        idle();
        checkBitOutput("single_inst_rvalid", INST_RVALID, 1'b1);
        checkOutput("single_inst_roaddr", INST_ROADDR, 32'h100);
        checkOutput("single_inst_rdata", INST_RDATA, 32'hDEADBEEF);
        checkBitOutput("single_data_rvalid", DATA_RVALID, 1'b0);
        endCycle();
        idle();
        checkBitOutput("single_rvalid_pulse", INST_RVALID, 1'b0);

        // Contention: grants D,D,D,D,I repeating; MMU answers each issue one cycle later
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 32'h1000, 1, 32'h2000, 0, 0, (k > 0), 32'h3000 + k, 32'h0);
            checkOutput("cont_mem_riaddr", MEM_RIADDR, ((k % 5) == 4) ? 32'h1000 : 32'h2000);
            checkBitOutput("cont_inst_wait", INST_WAIT, ((k % 5) != 4));
            checkBitOutput("cont_data_wait", DATA_WAIT, ((k % 5) == 4));
            if (k >= 2) checkBitOutput("cont_inst_rvalid", INST_RVALID, (((k - 2) % 5) == 4));
            endCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h300A, 32'h0);
        endCycle();
        idle();
        endCycle();

        // Queue full: I,D,I,D then both requesters blocked
        applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        endCycle();
        applyStimulus(0, 0, 1, 32'h900, 0, 0, 0, 0, 0);
        endCycle();
        applyStimulus(1, 32'h304, 0, 0, 0, 0, 0, 0, 0);
        endCycle();
        applyStimulus(0, 0, 1, 32'h904, 0, 0, 0, 0, 0);
        endCycle();
        applyStimulus(1, 32'h308, 1, 32'h908, 0, 0, 0, 0, 0);
        checkBitOutput("full_mem_rden", MEM_RDEN, 1'b0);
        checkBitOutput("full_inst_wait", INST_WAIT, 1'b1);
        checkBitOutput("full_data_wait", DATA_WAIT, 1'b1);
        endCycle();
        applyStimulus(1, 32'h308, 1, 32'h908, 0, 0, 1, 32'h300, 32'h11);
        checkBitOutput("full_pop_no_issue", MEM_RDEN, 1'b0);
        checkBitOutput("full_pop_data_wait", DATA_WAIT, 1'b1);
        endCycle();
        applyStimulus(1, 32'h308, 1, 32'h908, 0, 0, 0, 0, 0);
        checkBitOutput("after_pop_mem_rden", MEM_RDEN, 1'b1);
        checkOutput("after_pop_mem_riaddr", MEM_RIADDR, 32'h908);
        checkBitOutput("after_pop_data_wait", DATA_WAIT, 1'b0);
        checkBitOutput("after_pop_inst_wait", INST_WAIT, 1'b1);
        checkBitOutput("full_resp0_inst_rvalid", INST_RVALID, 1'b1);
        checkOutput("full_resp0_inst_roaddr", INST_ROADDR, 32'h300);
        checkOutput("full_resp0_inst_rdata", INST_RDATA, 32'h11);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h900, 32'h22);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h304, 32'h33);
        checkBitOutput("full_resp1_data_rvalid", DATA_RVALID, 1'b1);
        checkBitOutput("full_resp1_inst_rvalid", INST_RVALID, 1'b0);
        checkOutput("full_resp1_data_roaddr", DATA_ROADDR, 32'h900);
        checkOutput("full_resp1_data_rdata", DATA_RDATA, 32'h22);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h904, 32'h44);
        checkBitOutput("full_resp2_inst_rvalid", INST_RVALID, 1'b1);
        checkBitOutput("full_resp2_data_rvalid", DATA_RVALID, 1'b0);
        checkOutput("full_resp2_inst_roaddr", INST_ROADDR, 32'h304);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h908, 32'h55);
        checkBitOutput("full_resp3_data_rvalid", DATA_RVALID, 1'b1);
        checkOutput("full_resp3_data_roaddr", DATA_ROADDR, 32'h904);
        endCycle();
        idle();
        checkBitOutput("full_resp4_data_rvalid", DATA_RVALID, 1'b1);
        checkOutput("full_resp4_data_roaddr", DATA_ROADDR, 32'h908);
        checkOutput("full_resp4_data_rdata", DATA_RDATA, 32'h55);
        checkBitOutput("full_err_clear", ERR, 1'b0);
        endCycle();

        // MEM_WAIT stall for five cycles
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 32'hA00, 0, 1, 0, 0, 0);
            checkBitOutput("wait_data_wait", DATA_WAIT, 1'b1);
            checkOutput("wait_mem_riaddr", MEM_RIADDR, 32'hA00);
            checkBitOutput("wait_mem_rden", MEM_RDEN, 1'b1);
            endCycle();
        end
        applyStimulus(0, 0, 1, 32'hA00, 0, 0, 0, 0, 0);
        checkBitOutput("wait_release_data_wait", DATA_WAIT, 1'b0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hA00, 32'h66);
        endCycle();
        idle();
        checkBitOutput("wait_resp_data_rvalid", DATA_RVALID, 1'b1);
        checkOutput("wait_resp_data_roaddr", DATA_ROADDR, 32'hA00);
        checkBitOutput("wait_single_push_err", ERR, 1'b0);
        endCycle();

        // FLUSH with I(0x200), D(0x800), I(0x204) outstanding; head popped during FLUSH
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
        endCycle();
        applyStimulus(0, 0, 1, 32'h800, 0, 0, 0, 0, 0);
        endCycle();
        applyStimulus(1, 32'h204, 0, 0, 0, 0, 0, 0, 0);
        endCycle();
        applyStimulus(1, 32'h208, 0, 0, 1, 0, 1, 32'h200, 32'h70);
        checkBitOutput("flush_mem_rden", MEM_RDEN, 1'b0);
        checkBitOutput("flush_inst_wait", INST_WAIT, 1'b1);
        endCycle();
        applyStimulus(1, 32'h208, 0, 0, 0, 0, 1, 32'h800, 32'h77);
        checkBitOutput("flush_head_dropped", INST_RVALID, 1'b0);
        checkBitOutput("post_flush_mem_rden", MEM_RDEN, 1'b1);
        checkOutput("post_flush_mem_riaddr", MEM_RIADDR, 32'h208);
        checkBitOutput("post_flush_inst_wait", INST_WAIT, 1'b0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h204, 32'h88);
        checkBitOutput("flush_data_rvalid", DATA_RVALID, 1'b1);
        checkOutput("flush_data_roaddr", DATA_ROADDR, 32'h800);
        checkOutput("flush_data_rdata", DATA_RDATA, 32'h77);
        checkBitOutput("flush_data_inst_rvalid", INST_RVALID, 1'b0);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h208, 32'h99);
        checkBitOutput("flush_second_dropped", INST_RVALID, 1'b0);
        checkBitOutput("flush_second_data_rvalid", DATA_RVALID, 1'b0);
        endCycle();
        idle();
        checkBitOutput("post_flush_inst_rvalid", INST_RVALID, 1'b1);
        checkOutput("post_flush_inst_roaddr", INST_ROADDR, 32'h208);
        checkOutput("post_flush_inst_rdata", INST_RDATA, 32'h99);
        endCycle();

        // Spurious response with the queue empty
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hBAD, 32'h1);
        checkBitOutput("spur_err_before", ERR, 1'b0);
        endCycle();
        idle();
        checkBitOutput("spur_err_set", ERR, 1'b1);
        checkBitOutput("spur_inst_rvalid", INST_RVALID, 1'b0);
        checkBitOutput("spur_data_rvalid", DATA_RVALID, 1'b0);
        endCycle();
        applyStimulus(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        checkBitOutput("spur_err_sticky", ERR, 1'b1);
        checkBitOutput("spur_count_zero_issue", MEM_RDEN, 1'b1);
        endCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h400, 32'hAB);
        endCycle();
        idle();
        checkBitOutput("spur_next_inst_rvalid", INST_RVALID, 1'b1);
        checkOutput("spur_next_inst_roaddr", INST_ROADDR, 32'h400);
        endCycle();
        RST = 1'b1;
        endCycle();
        RST = 1'b0;
        idle();
        checkBitOutput("rst2_err", ERR, 1'b0);
        checkOutput("rst2_inst_roaddr", INST_ROADDR, 32'h0);
        checkBitOutput("rst2_mem_rden", MEM_RDEN, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
